// File: rtl/bin_to_bcd_seq_if.sv
// Operand/result channel between a binary producer, the converter and the BCD consumer.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// valid never waits on ready, and the sender holds data stable until the transfer edge.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  busy;

    modport master (
        output in_valid,
        output bin_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bcd_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  bin_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bcd_out,
        output busy
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock,
// with valid/ready on both sides so it can stall inside a pipeline.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus,
    output logic [1:0]        dbg_state
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // All digits are corrected from their pre-shift values in the same cycle.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    bin_d   = bus.bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                // bcd_out only ever receives the finished scratch value.
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = scr_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.bcd_out   = bcd_q;
    assign dbg_state     = state_q;
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one iteration per clock. It is the stage directly upstream of the team's BCD digit adder: it turns binary operands into packed BCD digits that the adder consumes. It uses a valid/ready handshake on both input and output, so it can sit in a stalled pipeline.

Parameters:
BIN_W, 8, width of binary input; must be >= 1.
DIGITS, 3, number of BCD output digits. Requires 10^DIGITS > 2^BIN_W - 1; the bench checks this constraint at elaboration.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  bin_in holds a value to convert.
in_ready  output  1  converter can accept an operand (high only in IDLE).
bin_in  input  BIN_W  unsigned binary operand.
out_valid  output  1  bcd_out holds a completed result.
out_ready  input  1  downstream accepts the result.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) is bits [3:0], digit i is bits [4i+3:4i].
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; bcd_out = 0; busy = 0.
  - Internal shift and scratch registers and the iteration counter = 0.
  - in_ready = 1 once reset deasserts.
- States:
  - IDLE: in_ready = 1. On a rising edge with in_valid = 1, latch bin_in into the binary shift register, clear the BCD scratch register and counter, go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle performs one iteration:
    - Every scratch digit >= 5 gets +3 (4-bit add, no carry out).
    - The concatenation {scratch, binary} then shifts left by 1.
    - The counter increments.
    - The iteration that makes counter == BIN_W also copies the post-shift scratch into bcd_out, sets out_valid = 1 and goes to DONE.
  - DONE: out_valid = 1, in_ready = 0. bcd_out is stable. On a rising edge with out_ready = 1: out_valid = 0, go to IDLE.
- Latency:
  - Acceptance at edge E0; out_valid rises after edge E0 + BIN_W (8 cycles for the default).
  - Minimum initiation interval is BIN_W + 2 cycles.
- Digit rule: the add-3 check uses pre-shift digit values only, in the same cycle for all digits. No digit ever exceeds 9 in the final result.
- bcd_out holds the last result after the output handshake, until the next conversion completes. It never shows intermediate scratch values.
- Boundary conditions:
  - in_valid while busy: ignored, no capture, no effect on the conversion in progress.
  - bin_in may change freely after the acceptance edge.
  - out_ready high before out_valid: no effect.
  - out_ready held low: stay in DONE indefinitely with bcd_out and out_valid stable.
  - in_valid and out_ready both high in DONE: only the output handshake completes. The input is accepted at the earliest on the next edge, once in IDLE.
  - bin_in = 0: still runs the full BIN_W iterations and produces all-zero digits.
  - Maximum input (2^BIN_W - 1): converts exactly within the DIGITS constraint; no overflow flag.
  - rst_n asserted mid-SHIFT or mid-DONE: conversion aborted immediately, all outputs take reset values, no partial result appears on bcd_out.
- The datapath is purely arithmetic and deterministic.

Test Plan:
- Reset, then bin_in = 255 with in_valid pulsed one cycle and out_ready = 1 -> out_valid high exactly 8 cycles after acceptance; bcd_out = 0x255; in_ready = 0 during conversion.
- Back-to-back conversions of 0, 9, 10, 99 -> bcd_out = 0x000, 0x009, 0x010, 0x099; each out_valid 8 cycles after its acceptance; in_ready returns 1 the cycle after each output handshake.
- bin_in = 128, out_ready held low 5 cycles after out_valid rises -> bcd_out = 0x128 stable and out_valid high for all 5 cycles; cleared one edge after out_ready = 1.
- During a conversion of 200, toggle in_valid with bin_in = 17 -> 17 is ignored; result is 0x200. A later conversion of 17 gives 0x017.
- Assert rst_n low at iteration 4 of converting 173 -> out_valid = 0 and bcd_out = 0 immediately (asynchronous). After release, converting 173 yields 0x173.
- Exhaustive sweep of 0..255 with random out_ready stalls -> every result equals the decimal digits of the input; no digit > 9.
